// File: rtl/uart_const_baud_rx.sv
// Fixed-baud 8N1 UART receiver.
// The line is synchronized and edge-detected. A half-bit delay lands the
// sampling point mid-bit, and the frame is then sampled once per bit period.
// rx_data is updated only on a good stop bit. A low stop bit raises the
// rx_err pulse instead.
`timescale 1ns/1ps
module uart_const_baud_rx #(
    parameter int clock_freq = 100_000_000,
    parameter int baud_rate  = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       rx_err,
    output logic       rx_busy
);

    localparam int BAUD_LIMIT = clock_freq / baud_rate;
    localparam int HALF_LIMIT = BAUD_LIMIT / 2;
    localparam int CW         = $clog2(BAUD_LIMIT + 1);

    // Terminal counts: a full bit period, and half a bit for the start check
    localparam logic [CW-1:0] BAUD_TC = CW'(BAUD_LIMIT - 1);
    localparam logic [CW-1:0] HALF_TC = CW'(HALF_LIMIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // Synchronizer chain: rx_m (metastable) -> rx_s (clean) -> rx_d (delayed)
    logic rx_m, rx_s, rx_d;
    logic start_edge;

    state_t        state, state_nxt;
    logic [CW-1:0] baud_cnt, cnt_nxt;
    logic [2:0]    bit_idx, idx_nxt;
    logic [7:0]    shift, shift_nxt;
    logic [7:0]    data_nxt;
    logic          done_nxt, err_nxt, busy_nxt;

    // Two-FF synchronizer plus one delay stage for edge detection. The chain
    // resets to the idle level, so the line looks idle after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_d <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
            rx_d <= rx_s;
        end
    end

    // A start is a falling edge. A line held low never re-arms IDLE.
    assign start_edge = rx_d & ~rx_s;

    // State, counters, shifter and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            rx_data  <= '0;
            rx_done  <= 1'b0;
            rx_err   <= 1'b0;
            rx_busy  <= 1'b0;
        end else begin
            state    <= state_nxt;
            baud_cnt <= cnt_nxt;
            bit_idx  <= idx_nxt;
            shift    <= shift_nxt;
            rx_data  <= data_nxt;
            rx_done  <= done_nxt;
            rx_err   <= err_nxt;
            rx_busy  <= busy_nxt;
        end
    end

    // Next-state logic. Pulses default low, so each strobe lasts exactly one cycle.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = baud_cnt;
        idx_nxt   = bit_idx;
        shift_nxt = shift;
        data_nxt  = rx_data;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;

        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (start_edge) begin
                    state_nxt = START;
                end
            end

            // Wait half a bit, then confirm the line is still low. A line
            // that has gone back high is a glitch and is dropped silently.
            START: begin
                if (baud_cnt == HALF_TC) begin
                    cnt_nxt = '0;
                    if (!rx_s) begin
                        state_nxt = DATA;
                        idx_nxt   = '0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = baud_cnt + CW'(1);
                end
            end

            // Sample mid-bit and shift LSB-first data in from the top
            DATA: begin
                if (baud_cnt == BAUD_TC) begin
                    cnt_nxt   = '0;
                    shift_nxt = {rx_s, shift[7:1]};
                    idx_nxt   = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_nxt = STOP;
                    end
                end else begin
                    cnt_nxt = baud_cnt + CW'(1);
                end
            end

            // Only a high stop bit commits the byte
            STOP: begin
                if (baud_cnt == BAUD_TC) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                    if (rx_s) begin
                        data_nxt = shift;
                        done_nxt = 1'b1;
                    end else begin
                        err_nxt  = 1'b1;
                    end
                end else begin
                    cnt_nxt = baud_cnt + CW'(1);
                end
            end

            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase

        // busy follows the state being entered, so it tracks START/IDLE entry
        busy_nxt = (state_nxt != IDLE);
    end

endmodule
